// File: rtl/rf_pkg.sv
// Shared defaults and dump-state encoding for the register file and its dump controller.
package rf_pkg;

    localparam int unsigned RF_WIDTH  = 8;
    localparam int unsigned RF_DEPTH  = 8;
    localparam int unsigned RF_ADDR_W = $clog2(RF_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } dump_state_e;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Dump FSM: streams every register out with valid/ready handshaking and registered beat outputs.
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH  = RF_WIDTH,
    parameter int unsigned DEPTH  = RF_DEPTH,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_snap_idx,
    input  logic [WIDTH-1:0]  i_snap_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_idx,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  w_data_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              w_hs;

    assign w_hs       = r_valid & i_ready;
    // Index loaded on the next handshake; the parent returns its bypassed value.
    assign o_snap_idx = r_idx + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    // Register 0 is hard-wired to zero, so the first beat needs no lookup.
                    w_state_nxt = ST_DUMP;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = '0;
                    w_data_nxt  = '0;
                    w_last_nxt  = (LAST_IDX == '0);
                end
            end
            ST_DUMP: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_idx_nxt   = '0;
                        w_data_nxt  = '0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt   = o_snap_idx;
                        w_data_nxt  = i_snap_data;
                        w_last_nxt  = (o_snap_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with r0 hard-wired to zero, write-through bypass, and a dump stream.
module reg_file
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH  = RF_WIDTH,
    parameter int unsigned DEPTH  = RF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_last,
    output logic              busy
);

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic              w_wr_en;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_hit_s;
    logic [ADDR_W-1:0] w_snap_idx;
    logic [WIDTH-1:0]  w_snap_data;

    assign w_wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Bypass only on a real write: a write to r0 is discarded, so r0 stays zero on every port.
    assign w_hit_a     = w_wr_en && (waddr == raddr_a);
    assign w_hit_b     = w_wr_en && (waddr == raddr_b);
    assign w_hit_s     = w_wr_en && (waddr == w_snap_idx);

    assign rdata_a     = w_hit_a ? wdata : r_regs[raddr_a];
    assign rdata_b     = w_hit_b ? wdata : r_regs[raddr_b];
    assign w_snap_data = w_hit_s ? wdata : r_regs[w_snap_idx];

    rf_dump_ctrl #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .clk         (clk),
        .rst_n       (reset),
        .i_start     (dump_start),
        .i_ready     (dump_ready),
        .o_snap_idx  (w_snap_idx),
        .i_snap_data (w_snap_data),
        .o_valid     (dump_valid),
        .o_idx       (dump_idx),
        .o_data      (dump_data),
        .o_last      (dump_last),
        .o_busy      (busy)
    );

endmodule
